// File: rtl/mode_sequencer.sv
// Mode sequencer: keeps one of N_MODES pattern blocks enabled, with a guard gap between modes,
// online preemption and an optional stall watchdog (enabled by defining MODE_WDT_EN).
module mode_sequencer #(
    parameter int N_MODES = 6,
    parameter int SEL_W   = 2,
    parameter int GAP_CYC = 2,
    parameter int WDT_CYC = 1024,
    parameter int IDX_W   = $clog2(N_MODES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               online_req,
    input  logic               reset_req,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N_MODES-1:0] done,
    output logic [N_MODES-1:0] enb,
    output logic [IDX_W-1:0]   cur_mode,
    output logic               busy,
    output logic               wdt_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   cur_mode_reg, cur_mode_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic               force_rst_reg, force_rst_next;

    logic [N_MODES-1:0] mode_hit;
    logic               done_cur;
    logic               preempt;
    logic               run_end;
    logic               wdt_fire;
    logic [31:0]        norm_idx;
    logic [IDX_W-1:0]   sel_idx;

    // One decoder serves both the done filter and the one-hot enable.
    genvar gi;
    generate
        for (gi = 0; gi < N_MODES; gi++) begin : g_mode
            assign mode_hit[gi] = (cur_mode_reg == IDX_W'(gi));
        end
    endgenerate

    assign done_cur = |(done & mode_hit);
    assign preempt  = online_req && (cur_mode_reg != '0);

    // Priority selection; out-of-range normal codes fall back to the first normal mode.
    always_comb begin
        norm_idx = 32'(sel) + 32'd2;
        if (online_req) begin
            sel_idx = IDX_W'(0);
        end else if (reset_req) begin
            sel_idx = IDX_W'(1);
        end else if (norm_idx > 32'(N_MODES - 1)) begin
            sel_idx = IDX_W'(2);
        end else begin
            sel_idx = IDX_W'(norm_idx);
        end
    end

`ifdef MODE_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYC);

    logic [WDT_W-1:0] wdt_cnt_reg;
    logic             wdt_err_reg;

    assign wdt_fire = (state_reg == S_RUN) && (wdt_cnt_reg == WDT_W'(WDT_CYC - 1));

    // Counter restarts on every new mode, including back-to-back modes with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_reg <= '0;
            wdt_err_reg <= 1'b0;
        end else begin
            if (wdt_fire) begin
                wdt_err_reg <= 1'b1;
            end
            if (state_reg != S_RUN || run_end) begin
                wdt_cnt_reg <= '0;
            end else begin
                wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
            end
        end
    end

    assign wdt_err = wdt_err_reg;
`else
    assign wdt_fire = 1'b0;
    assign wdt_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cur_mode_reg  <= '0;
            gap_cnt_reg   <= '0;
            force_rst_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_mode_reg  <= cur_mode_next;
            gap_cnt_reg   <= gap_cnt_next;
            force_rst_reg <= force_rst_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cur_mode_next  = cur_mode_reg;
        gap_cnt_next   = gap_cnt_reg;
        force_rst_next = force_rst_reg;
        run_end        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                gap_cnt_next   = '0;
                force_rst_next = 1'b0;
                if (start) begin
                    state_next    = S_RUN;
                    cur_mode_next = sel_idx;
                end
            end
            S_RUN: begin
                run_end      = wdt_fire || done_cur || preempt;
                gap_cnt_next = '0;
                if (run_end) begin
                    if (stop) begin
                        state_next = S_IDLE;
                    end else if (GAP_CYC > 0) begin
                        // Remember a watchdog end so the gap exit picks the reset pattern.
                        state_next     = S_GAP;
                        force_rst_next = wdt_fire;
                    end else begin
                        cur_mode_next = wdt_fire ? IDX_W'(1) : sel_idx;
                    end
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_next     = S_IDLE;
                    force_rst_next = 1'b0;
                    gap_cnt_next   = '0;
                end else if (gap_cnt_reg == GAP_W'(GAP_LAST)) begin
                    state_next     = S_RUN;
                    cur_mode_next  = force_rst_reg ? IDX_W'(1) : sel_idx;
                    force_rst_next = 1'b0;
                    gap_cnt_next   = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        enb      = (state_reg == S_RUN) ? mode_hit : '0;
        busy     = (state_reg != S_IDLE);
        cur_mode = cur_mode_reg;
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// Scoreboard bench for mode_sequencer: a 6-mode/2-gap instance and a 5-mode/zero-gap instance.
module tb_mode_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, stop, online_req, reset_req;
    logic [1:0] sel;
    logic [5:0] done;
    logic [4:0] z_done;

    logic [5:0] enb;
    logic [2:0] cur_mode;
    logic       busy, wdt_err;
    logic [4:0] z_enb;
    logic [2:0] z_cur;
    logic       z_busy, z_wdt;

    mode_sequencer #(.N_MODES(6), .SEL_W(2), .GAP_CYC(2), .WDT_CYC(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .online_req(online_req), .reset_req(reset_req), .sel(sel), .done(done),
        .enb(enb), .cur_mode(cur_mode), .busy(busy), .wdt_err(wdt_err)
    );

    mode_sequencer #(.N_MODES(5), .SEL_W(2), .GAP_CYC(0), .WDT_CYC(16)) zdut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .online_req(online_req), .reset_req(reset_req), .sel(sel), .done(z_done),
        .enb(z_enb), .cur_mode(z_cur), .busy(z_busy), .wdt_err(z_wdt)
    );

    typedef struct {
        string      tag;
        logic       z;
        logic [5:0] enb;
        logic       busy;
        logic [2:0] cur;
        logic       wdt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_wdt = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Push the expectation for the coming edge, then pop it once the DUT has responded.
    task automatic cyc(input string tag, input logic z, input logic [5:0] e_enb,
                       input logic e_busy, input logic [2:0] e_cur);
        exp_t e;
        e.tag = tag; e.z = z; e.enb = e_enb; e.busy = e_busy; e.cur = e_cur; e.wdt = exp_wdt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (!e.z) begin
            $display("[%0t] %s enb=%b busy=%b cur=%0d wdt=%b", $time, e.tag, enb, busy, cur_mode, wdt_err);
            check({e.tag, ".enb"},  32'(enb),      32'(e.enb));
            check({e.tag, ".busy"}, 32'(busy),     32'(e.busy));
            check({e.tag, ".cur"},  32'(cur_mode), 32'(e.cur));
            check({e.tag, ".wdt"},  32'(wdt_err),  32'(e.wdt));
        end else begin
            $display("[%0t] %s z_enb=%b z_busy=%b z_cur=%0d", $time, e.tag, z_enb, z_busy, z_cur);
            check({e.tag, ".enb"},  32'(z_enb),  32'(e.enb));
            check({e.tag, ".busy"}, 32'(z_busy), 32'(e.busy));
            check({e.tag, ".cur"},  32'(z_cur),  32'(e.cur));
            check({e.tag, ".wdt"},  32'(z_wdt),  32'(1'b0));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; online_req = 1'b0; reset_req = 1'b0;
        sel = 2'd0; done = '0; z_done = '0;

        cyc("rst0", 0, 6'b000000, 0, 0);
        cyc("rst1", 0, 6'b000000, 0, 0);
        rst = 1'b0;
        repeat (20) cyc("idle", 0, 6'b000000, 0, 0);

        // Normal flow: mode 5, done, two-cycle gap, mode 5 again
        sel = 2'b11; start = 1'b1;
        cyc("start5", 0, 6'b100000, 1, 5);
        start = 1'b0;
        repeat (2) cyc("run5", 0, 6'b100000, 1, 5);
        done = 6'b100000;
        cyc("gap5a", 0, 6'b000000, 1, 5);
        done = '0;
        cyc("gap5b", 0, 6'b000000, 1, 5);
        cyc("again5", 0, 6'b100000, 1, 5);

        // Priority: online beats reset during the gap
        done = 6'b100000;
        cyc("pgap_a", 0, 6'b000000, 1, 5);
        done = '0; online_req = 1'b1; reset_req = 1'b1;
        cyc("pgap_b", 0, 6'b000000, 1, 5);
        cyc("online", 0, 6'b000001, 1, 0);
        online_req = 1'b0; done = 6'b000001;
        cyc("rgap_a", 0, 6'b000000, 1, 0);
        done = '0;
        cyc("rgap_b", 0, 6'b000000, 1, 0);
        cyc("resetm", 0, 6'b000010, 1, 1);

        // Into mode 3; foreign done and input changes mid-RUN are ignored
        reset_req = 1'b0; sel = 2'd1; done = 6'b000010;
        cyc("g3a", 0, 6'b000000, 1, 1);
        done = '0;
        cyc("g3b", 0, 6'b000000, 1, 1);
        cyc("mode3", 0, 6'b001000, 1, 3);
        done = 6'b000100;
        cyc("foreign_done", 0, 6'b001000, 1, 3);
        done = '0; sel = 2'd2; reset_req = 1'b1;
        cyc("sel_mid_run", 0, 6'b001000, 1, 3);
        reset_req = 1'b0;

        // Preemption from mode 3
        online_req = 1'b1;
        cyc("pre_a", 0, 6'b000000, 1, 3);
        cyc("pre_b", 0, 6'b000000, 1, 3);
        cyc("pre_on", 0, 6'b000001, 1, 0);
        cyc("no_self_pre", 0, 6'b000001, 1, 0);
        online_req = 1'b0;

        // Stop at mode end, then stop during a gap
        stop = 1'b1; done = 6'b000001;
        cyc("stop_end", 0, 6'b000000, 0, 0);
        done = '0;
        cyc("stop_idle", 0, 6'b000000, 0, 0);
        stop = 1'b0;
        cyc("idle2", 0, 6'b000000, 0, 0);
        sel = 2'd0; start = 1'b1;
        cyc("start2", 0, 6'b000100, 1, 2);
        start = 1'b0; done = 6'b000100;
        cyc("gap2", 0, 6'b000000, 1, 2);
        done = '0; stop = 1'b1;
        cyc("stop_gap", 0, 6'b000000, 0, 2);
        stop = 1'b0;
        cyc("hold_cur", 0, 6'b000000, 0, 2);

        // Watchdog on a stalled mode 4
        rst = 1'b1;
        cyc("wrst", 0, 6'b000000, 0, 0);
        rst = 1'b0; sel = 2'd2; start = 1'b1;
        cyc("wstart", 0, 6'b010000, 1, 4);
        start = 1'b0;
`ifdef MODE_WDT_EN
        repeat (15) cyc("wrun", 0, 6'b010000, 1, 4);
        exp_wdt = 1'b1;
        cyc("wfire", 0, 6'b000000, 1, 4);
        cyc("wgap", 0, 6'b000000, 1, 4);
        cyc("wreset", 0, 6'b000010, 1, 1);
        repeat (3) cyc("wsticky", 0, 6'b000010, 1, 1);
        stop = 1'b1; done = 6'b000010;
        cyc("wstop", 0, 6'b000000, 0, 1);
        stop = 1'b0; done = '0;
        rst = 1'b1; exp_wdt = 1'b0;
        cyc("wclear", 0, 6'b000000, 0, 0);
`else
        repeat (20) cyc("nowdt", 0, 6'b010000, 1, 4);
        stop = 1'b1; done = 6'b010000;
        cyc("nwstop", 0, 6'b000000, 0, 4);
        stop = 1'b0; done = '0;
        rst = 1'b1;
        cyc("nwrst", 0, 6'b000000, 0, 0);
`endif

        // Zero-gap instance (5 modes)
        cyc("zrst", 1, 6'b000000, 0, 0);
        rst = 1'b0; sel = 2'd1; start = 1'b1;
        cyc("zstart3", 1, 6'b001000, 1, 3);
        start = 1'b0; z_done = 5'b01000;
        cyc("zsame", 1, 6'b001000, 1, 3);
        z_done = '0;
        cyc("zrun3", 1, 6'b001000, 1, 3);
        sel = 2'd3; z_done = 5'b01000;
        cyc("zclamp2", 1, 6'b000100, 1, 2);
        z_done = '0;
        cyc("zrun2", 1, 6'b000100, 1, 2);
        online_req = 1'b1;
        cyc("zpre", 1, 6'b000001, 1, 0);
        online_req = 1'b0;
        cyc("zrun0", 1, 6'b000001, 1, 0);
        stop = 1'b1; z_done = 5'b00001;
        cyc("zstop", 1, 6'b000000, 0, 0);
        stop = 1'b0; z_done = '0;
        cyc("zidle", 1, 6'b000000, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
